// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// func3 op codes, the M-extension funct7 code, FSM state encoding and a
// small two's-complement helper.
package muldiv_unit_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_CNT_W = 6;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_CALC = 2'd1,
    MD_STATE_DONE = 2'd2
  } md_state_t;

  // Conditionally negate a 32-bit value (two's complement).
  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational iteration of the multiply/divide datapath.
// Multiply: acc = {hi, lo}; lo holds the remaining multiplier bits and the
//   multiplicand (i_opd) is added into hi when lo[0] is set, then the whole
//   65-bit {carry, hi, lo} shifts right by one.
// Divide (restoring): acc = {rem, quo}; {rem, quo} shifts left by one, the
//   divisor (i_opd) is trial-subtracted from rem and the quotient bit is set
//   when the difference is non-negative.
module muldiv_iter_step (
  input  logic        i_is_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_opd,
  output logic [63:0] o_acc
);

  logic [32:0] w_sum;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_diff;

  assign w_sum    = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opd} : 33'd0);
  assign w_rem_sh = {i_acc[63:32], i_acc[31]};
  assign w_ge     = (w_rem_sh >= {1'b0, i_opd});
  // When w_ge holds the true difference is below the divisor, so 32 bits suffice.
  assign w_diff   = w_rem_sh[31:0] - i_opd;

  // Select the shift-add or restoring-divide step result.
  always_comb begin
    o_acc = {w_sum, i_acc[31:1]};
    if (i_is_div) begin
      if (w_ge) o_acc = {w_diff, i_acc[30:0], 1'b1};
      else      o_acc = {w_rem_sh[31:0], i_acc[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide execution unit. Operands are converted to
// magnitudes at launch, a 32-iteration shift-add or restoring-divide runs in
// CALC, and the sign fix-up is applied on the way into DONE. Divide by zero
// and signed overflow skip CALC entirely.
// Optional macro FAST_MUL_EN: multiplies finish in one cycle using a single
// 33x33 signed multiply at launch; divides are unaffected.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  o_dbg_state
);

  md_state_t             r_state;
  logic [2:0]            r_func3;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic [63:0]           r_acc;
  logic [31:0]           r_opd;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic [31:0]           r_fin;
  logic [31:0]           r_result;

  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_val;
  logic [63:0] w_step_acc;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_final;

  // Launch-side decode: which operands are signed, and their magnitudes.
  assign w_sa = op_a[31] & ((func3 == MULDIV_OP_MULH) | (func3 == MULDIV_OP_MULHSU) |
                            (func3 == MULDIV_OP_DIV)  | (func3 == MULDIV_OP_REM));
  assign w_sb = op_b[31] & ((func3 == MULDIV_OP_MULH) | (func3 == MULDIV_OP_DIV) |
                            (func3 == MULDIV_OP_REM));
  assign w_mag_a = neg_if(w_sa, op_a);
  assign w_mag_b = neg_if(w_sb, op_b);

  assign w_div_zero = func3[2] & (op_b == 32'd0);
  assign w_div_ovf  = ((func3 == MULDIV_OP_DIV) | (func3 == MULDIV_OP_REM)) &
                      (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);

`ifdef FAST_MUL_EN
  logic [32:0]        w_fa;
  logic [32:0]        w_fb;
  logic signed [63:0] w_fast_prod;
  logic [31:0]        w_fast_val;

  assign w_fa        = {w_sa, op_a};
  assign w_fb        = {w_sb, op_b};
  assign w_fast_prod = $signed({{31{w_fa[32]}}, w_fa}) * $signed({{31{w_fb[32]}}, w_fb});
  assign w_fast_val  = (func3 == MULDIV_OP_MUL) ? w_fast_prod[31:0] : w_fast_prod[63:32];
  assign w_special   = w_div_zero | w_div_ovf | ~func3[2];
`else
  assign w_special   = w_div_zero | w_div_ovf;
`endif

  // Result for operations that bypass the iterative path.
  always_comb begin
    w_special_val = 32'd0;
    if (w_div_zero)     w_special_val = func3[1] ? op_a  : 32'hFFFF_FFFF;
    else if (w_div_ovf) w_special_val = func3[1] ? 32'd0 : 32'h8000_0000;
`ifdef FAST_MUL_EN
    if (!func3[2])      w_special_val = w_fast_val;
`endif
  end

  muldiv_iter_step u_step (
    .i_is_div (r_func3[2]),
    .i_acc    (r_acc),
    .i_opd    (r_opd),
    .o_acc    (w_step_acc)
  );

  // Sign fix-up applied to the value produced by the final iteration.
  assign w_prod = (r_sign_a ^ r_sign_b) ? (~w_step_acc + 64'd1) : w_step_acc;
  assign w_quo  = neg_if(r_sign_a ^ r_sign_b, w_step_acc[31:0]);
  assign w_rem  = neg_if(r_sign_a, w_step_acc[63:32]);

  // Pick the architectural result for the latched op.
  always_comb begin
    w_final = w_rem;
    case (r_func3)
      MULDIV_OP_MUL:                                     w_final = w_prod[31:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: w_final = w_prod[63:32];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:                     w_final = w_quo;
      default:                                           w_final = w_rem;
    endcase
  end

  // Control FSM plus the iteration datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= MD_STATE_IDLE;
      r_func3  <= 3'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_acc    <= 64'd0;
      r_opd    <= 32'd0;
      r_cnt    <= '0;
      r_fin    <= 32'd0;
      r_result <= 32'd0;
    end else begin
      case (r_state)
        MD_STATE_IDLE: begin
          if (start && !flush) begin
            r_func3  <= func3;
            r_sign_a <= w_sa;
            r_sign_b <= w_sb;
            r_cnt    <= '0;
            if (func3[2]) begin
              r_acc <= {32'd0, w_mag_a};
              r_opd <= w_mag_b;
            end else begin
              r_acc <= {32'd0, w_mag_b};
              r_opd <= w_mag_a;
            end
            if (w_special) begin
              r_fin   <= w_special_val;
              r_state <= MD_STATE_DONE;
            end else begin
              r_state <= MD_STATE_CALC;
            end
          end
        end
        MD_STATE_CALC: begin
          if (flush) begin
            r_state <= MD_STATE_IDLE;
          end else begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt + {{(ITER_CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == ITER_CNT_W'(XLEN - 1)) begin
              r_fin   <= w_final;
              r_state <= MD_STATE_DONE;
            end
          end
        end
        MD_STATE_DONE: begin
          // A flushed op never becomes architecturally visible.
          if (!flush) r_result <= r_fin;
          r_state <= MD_STATE_IDLE;
        end
        default: r_state <= MD_STATE_IDLE;
      endcase
    end
  end

  // The done pulse and its result are killed by a same-cycle flush.
  assign busy        = (r_state != MD_STATE_IDLE);
  assign done        = (r_state == MD_STATE_DONE) && !flush;
  assign result      = done ? r_fin : r_result;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit. Stimulus drivers launch ops and push the
// expected result and completion cycle; a negedge monitor pops and compares
// on every done pulse. Expected values come from plain 64-bit arithmetic.
// Handshake: inputs change 1 time unit after posedge; start is sampled on the
// next posedge only while the unit is idle; done marks result valid for that
// cycle. Outputs are sampled on negedge or 1 unit after posedge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] exp_hold = 32'd0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .func3       (func3),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    longint      r;
    logic [63:0] ua64;
    logic [63:0] ub64;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = ua64 * ub64;  return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb;
        return r[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        r = sa % sb;
        return r[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 >= 3'd4 && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef FAST_MUL_EN
    if (f3 < 3'd4) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] t;
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      5: begin t = 32'($urandom_range(1, 255)); return ~t + 32'd1; end
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    int          ec;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", result, e);
        check("done_cycle", 32'(cyc), 32'(ec));
        exp_hold = e;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit push, output int n);
    start = 1'b1;
    func3 = f3;
    op_a  = a;
    op_b  = b;
    n     = cyc;
    if (push) begin
      exp_q.push_back(ref_model(f3, a, b));
      exp_cyc_q.push_back(n + ref_lat(f3, a, b));
    end
  endtask

  task automatic scramble();
    start = 1'b0;
    func3 = 3'($urandom_range(0, 7));
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int n;
    int k;
    wait_idle();
    launch(f3, a, b, 1'b1, n);
    @(posedge clk); #1;
    scramble();
    k = 0;
    while (busy && k < 40) begin
      k++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(k), 32'(ref_lat(f3, a, b)));
  endtask

  localparam int ND = 12;
  logic [2:0]  d_f3[ND] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a[ND]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                            32'hFFFF_FFF9, 32'd100, 32'd100, 32'd10, 32'd10, 32'h8000_0000,
                            32'h8000_0000};
  logic [31:0] d_b[ND]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operand table
    for (int i = 0; i < ND; i++) issue(d_f3[i], d_a[i], d_b[i]);

    // Flush in CALC at N+10, then a fresh launch at N+11
    wait_idle();
    launch(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
    @(posedge clk); #1;
    scramble();
    while (cyc < n + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_result_held", result, exp_hold);
    issue(3'd5, 32'd1000, 32'd9);

    // Flush during the DONE cycle of a single-cycle op
    wait_idle();
    launch(3'd5, 32'd10, 32'd0, 1'b0, n);
    @(posedge clk); #1;
    scramble();
    flush = 1'b1;
    #1;
    check("flush_in_done_pulse", 32'(done), 32'd0);
    check("flush_in_done_result", result, exp_hold);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_done_idle", 32'(busy), 32'd0);

    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; func3 = 3'd5; op_a = 32'd5; op_b = 32'd1;
    @(posedge clk); #1;
    scramble();
    flush = 1'b0;
    check("flush_beats_start", 32'(busy), 32'd0);

    // start while busy is ignored
    wait_idle();
    launch(3'd6, 32'hFFFF_FF00, 32'd7, 1'b1, n);
    @(posedge clk); #1;
    scramble();
    while (cyc < n + 5) begin @(posedge clk); #1; end
    start = 1'b1; func3 = 3'd3; op_a = $urandom; op_b = $urandom;
    @(posedge clk); #1;
    scramble();
    wait_idle();

    // Random operations
    for (int i = 0; i < 80; i++) issue(3'($urandom_range(0, 7)), pick(), pick());

    // Reset in the middle of an op
    wait_idle();
    launch(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, n);
    @(posedge clk); #1;
    scramble();
    while (cyc < n + 20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    rst_n = 1'b1;
    exp_hold = 32'd0;
    issue(3'd1, 32'h1234_5678, 32'h8765_4321);

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
